// File: rtl/mac_pkg.sv
// Shared types and helpers for the FIFO-draining dot-product engine.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package mac_pkg;

    // Encoded so that busy is simply "state is not IDLE".
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width for a counter that must be able to hold the value DEPTH.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mac_accum.sv
// Multiply-accumulate datapath: unsigned product added into a running sum.
// Latency: one cycle from acc_en to the updated accumulator; sum is combinational.
// Backpressure: none; accumulates whenever acc_en is high. MAC_SATURATE_EN clamps instead of wrapping.
module mac_accum
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [ACC_WIDTH-1:0]  sum
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH:0]      sum_wide;
    logic [ACC_WIDTH-1:0]    acc;

    // Product and the next accumulator value; the extra top bit is the carry out.
    always_comb begin
        prod     = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
        prod_ext = ACC_WIDTH'(prod);
        sum_wide = {1'b0, acc} + {1'b0, prod_ext};
`ifdef MAC_SATURATE_EN
        // Once the carry fires the sum pins at all-ones; adding more keeps it there.
        sum = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
        sum = sum_wide[ACC_WIDTH-1:0];
`endif
    end

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fifo_mac_drain.sv
// Pops paired operands from two registered-read FIFOs and emits a DEPTH-term dot product (MAC_SATURATE_EN selects saturation).
// Latency: result_valid pulses two cycles after the last pop of a batch.
// Backpressure: pops only while en=1 and both FIFOs are non-empty; never pops one side alone; no pops in drain/DONE.
module fifo_mac_drain
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int             CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        issued;
    logic [CW-1:0]        done_cnt;
    logic                 vld_q;
    logic                 pop;
    logic                 last_acc;
    logic                 acc_clr;
    logic                 acc_en;
    logic [ACC_WIDTH-1:0] sum;

    // Pop decision and the final-accumulate strobe.
    always_comb begin
        pop      = (state == RUN) && en && !clr && !a_empty && !b_empty && (issued < DEPTH_C);
        last_acc = (state == RUN) && vld_q && (done_cnt == LAST_C);
        acc_clr  = clr || (state != RUN);
        acc_en   = (state == RUN) && vld_q;
    end

    assign a_rden       = pop;
    assign b_rden       = pop;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !clr;

    // Next-state logic; clr forces IDLE from anywhere.
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state_nx = RUN;
                RUN:     if (last_acc) state_nx = DONE;
                DONE:    state_nx = en ? RUN : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Issue/complete counters and the read-data-valid pipeline bit; zero outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued   <= '0;
            done_cnt <= '0;
            vld_q    <= 1'b0;
        end else if (clr || (state != RUN)) begin
            issued   <= '0;
            done_cnt <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (pop) begin
                issued <= issued + 1'b1;
            end
            if (vld_q) begin
                done_cnt <= done_cnt + 1'b1;
            end
            vld_q <= pop;
        end
    end

    // Capture the completed sum on the edge that adds the last product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (last_acc && !clr) begin
            result <= sum;
        end
    end

    mac_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .acc_en (acc_en),
        .a_data (a_data),
        .b_data (b_data),
        .sum    (sum)
    );

endmodule

// File: doc/fifo_mac_drain.md
# fifo_mac_drain

Consumer stage sitting directly downstream of a pair of operand FIFOs (A and B). It pops one entry from each FIFO whenever both hold data and forms the product. It accumulates DEPTH products into one dot-product result and presents that result with a single-cycle valid pulse. It honours the FIFOs' registered-read behaviour: data appears one cycle after the read strobe.

## Interface
- DATA_WIDTH, 8, width of each FIFO operand (unsigned)
- DEPTH, 8, products per result; ≥2
- ACC_WIDTH, 24, accumulator/result width; ≥2*DATA_WIDTH
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  permit issuing new pops
- clr  in  1  synchronous abort/clear, priority over en
- a_empty  in  1  FIFO A empty flag
- b_empty  in  1  FIFO B empty flag
- a_data  in  DATA_WIDTH  FIFO A registered read data
- b_data  in  DATA_WIDTH  FIFO B registered read data
- a_rden  out  1  FIFO A read strobe
- b_rden  out  1  FIFO B read strobe (always equal to a_rden)
- result  out  ACC_WIDTH  last completed dot product
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE. States are encoded so that busy is a pure function of state.
- IDLE: counters and acc are zero. Go to RUN when en=1.
- RUN: pop = en & !a_empty & !b_empty & (issued < DEPTH). a_rden = b_rden = pop, combinational.
- issued increments on each pop. vld_q <= pop. When vld_q=1, acc <= acc + a_data*b_data, and done_cnt increments.
- When done_cnt reaches DEPTH on the accumulate edge, go to DONE and capture the final sum.
- DONE (one cycle): result <= final acc and result_valid=1. acc, issued and done_cnt clear. Next state is RUN if en=1, otherwise IDLE.
- Arithmetic is unsigned. The product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH unless the saturation feature is compiled in.
- If en drops mid-RUN, no new pops are issued. An in-flight accumulate still completes. The block stays in RUN and resumes when en returns.
- If either FIFO is empty, no pop occurs. The block never pops only one side.
- clr=1 in any state: the next state is IDLE and acc, issued, done_cnt and vld_q clear. Any in-flight data is discarded. result holds its value and result_valid=0. a_rden=0 while clr=1.
- Reset: state IDLE, a_rden=b_rden=0, result=0, result_valid=0, busy=0, acc=0.

## Timing
- Pop in cycle N: FIFO data is valid in cycle N+1, and acc updates at the end of N+1.
- Last pop in cycle N: result_valid is asserted in cycle N+2.
- Minimum batch length with FIFOs continuously non-empty: DEPTH pop cycles, then the drain cycle, then DONE.
- Back-to-back batches: there is no pop during the final drain cycle or during DONE. The first pop of the next batch occurs in the cycle after DONE.
- a_rden depends combinationally on a_empty, b_empty and en. There is no combinational path from a_data or b_data to any output.

## Configuration
- MAC_SATURATE_EN defined: when a sum would exceed 2^ACC_WIDTH-1, the accumulator clamps to all-ones and stays there until DONE or clr.
- MAC_SATURATE_EN undefined: the accumulator wraps modulo 2^ACC_WIDTH.

## Structure
- Package mac_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a localparam function for the counter width, $clog2(DEPTH+1).
- One sub-module, mac_accum, holds the multiplier, accumulator register, clear and the MAC_SATURATE_EN logic.
- The top level holds the FSM, the counters and the read strobes.

## Test plan
- Reset with en=1 and both FIFOs empty → a_rden=0, result=0, busy=0. en=1 with FIFOs empty → state RUN, no pops.
- A=1..8, B=all 2, DEPTH=8, FIFOs continuously non-empty → 8 consecutive pops, result=72, result_valid exactly once, 2 cycles after the last pop.
- B runs empty after 3 entries, then refilled 5 cycles later → no pops while empty; the final result is unchanged versus the uninterrupted case.
- en drops after 4 pops for 3 cycles → 4th product still accumulated, no pops while en=0, correct result on resume.
- clr asserted after 5 pops → busy=0 next cycle, result keeps its previous value, no result_valid pulse; the next batch result counts only new data.
- ACC_WIDTH=16, all operands 255, DEPTH=8 → without MAC_SATURATE_EN result=520200 mod 65536=61448; with it, result=65535.
